// File: rtl/code_table_ctrl.sv
// code_table_ctrl
// Port-A controller for the 4096-entry LZW code value RAM. Sweeps the table
// after init_start (literals 0..255 hold their own code, the rest EMPTY_VAL),
// then serves single-cycle inserts and two-cycle lookups from the compressor
// FSM while owning the next-code allocator.
module code_table_ctrl #(
  parameter int          TBL_DEPTH  = 4096,
  parameter logic [12:0] FIRST_CODE = 13'd258,
  parameter logic [12:0] EMPTY_VAL  = 13'h1FFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_start,
  output logic        init_busy,
  output logic        init_done,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [12:0] req_addr,
  output logic        rsp_valid,
  output logic        rsp_hit,
  output logic [12:0] rsp_data,
  output logic [12:0] next_code,
  output logic        table_full,
  output logic        ram_en,
  output logic        ram_wr,
  output logic [12:0] ram_addr,
  output logic [12:0] ram_wdata,
  input  logic [12:0] ram_rdata
);

  localparam logic [12:0] LAST_IDX  = 13'(TBL_DEPTH - 1);
  localparam logic [12:0] LITERALS  = 13'd256;
  localparam logic [12:0] FULL_CODE = 13'h1000;

  typedef enum logic [1:0] {IDLE, INIT, READY, RD_WAIT} state_t;

  state_t      state_reg, state_next;
  logic [12:0] cnt_reg, cnt_next;
  logic [12:0] next_code_reg, next_code_next;
  logic [12:0] hold_addr_reg, hold_addr_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic        rsp_hit_reg, rsp_hit_next;
  logic [12:0] rsp_data_reg, rsp_data_next;
  logic        init_done_reg, init_done_next;
  logic        full;

  assign full       = (next_code_reg == FULL_CODE);
  assign table_full = full;
  assign next_code  = next_code_reg;
  assign init_busy  = (state_reg == INIT);
  assign init_done  = init_done_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_hit    = rsp_hit_reg;
  assign rsp_data   = rsp_data_reg;

  // State, sweep counter, allocator and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      next_code_reg <= FIRST_CODE;
      hold_addr_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_hit_reg   <= 1'b0;
      rsp_data_reg  <= '0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      next_code_reg <= next_code_next;
      hold_addr_reg <= hold_addr_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_hit_reg   <= rsp_hit_next;
      rsp_data_reg  <= rsp_data_next;
      init_done_reg <= init_done_next;
    end
  end

  // Next-state, RAM port drive and response capture
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    next_code_next = next_code_reg;
    hold_addr_next = hold_addr_reg;
    rsp_valid_next = 1'b0;
    rsp_hit_next   = 1'b0;
    rsp_data_next  = '0;
    init_done_next = 1'b0;
    req_ready      = 1'b0;
    ram_en         = 1'b0;
    ram_wr         = 1'b0;
    ram_addr       = '0;
    ram_wdata      = '0;

    case (state_reg)
      IDLE: begin
        if (init_start) begin
          state_next = INIT;
          cnt_next   = '0;
        end
      end

      INIT: begin
        ram_en    = 1'b1;
        ram_wr    = 1'b1;
        ram_addr  = cnt_reg;
        ram_wdata = (cnt_reg < LITERALS) ? cnt_reg : EMPTY_VAL;
        if (cnt_reg == LAST_IDX) begin
          init_done_next = 1'b1;
          next_code_next = FIRST_CODE;
          cnt_next       = '0;
          state_next     = READY;
        end else begin
          cnt_next = cnt_reg + 13'd1;
        end
      end

      READY: begin
        // A simultaneous init_start wins and the request stays pending
        req_ready = ~init_start;
        if (init_start) begin
          state_next = INIT;
          cnt_next   = '0;
        end else if (req_valid) begin
          if (!req_op) begin
            ram_en         = 1'b1;
            ram_addr       = req_addr;
            hold_addr_next = req_addr;
            state_next     = RD_WAIT;
          end else if (!full) begin
            ram_en         = 1'b1;
            ram_wr         = 1'b1;
            ram_addr       = req_addr;
            ram_wdata      = next_code_reg;
            rsp_valid_next = 1'b1;
            rsp_hit_next   = 1'b1;
            rsp_data_next  = next_code_reg;
            next_code_next = next_code_reg + 13'd1;
          end else begin
            rsp_valid_next = 1'b1;
            rsp_hit_next   = 1'b0;
            rsp_data_next  = EMPTY_VAL;
          end
        end
      end

      RD_WAIT: begin
        // The RAM output bank mux still looks at addra[1:0] this cycle
        ram_addr       = hold_addr_reg;
        rsp_valid_next = 1'b1;
        rsp_data_next  = ram_rdata;
        rsp_hit_next   = (ram_rdata != EMPTY_VAL);
        state_next     = READY;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_code_table_ctrl.sv
// tb_code_table_ctrl
// Drives code_table_ctrl against a banked RAM with registered read and compares
// every cycle with a cycle-numbered reference model of the table contents,
// allocator and response timing.
module tb_code_table_ctrl;

  localparam int          TBL   = 4096;
  localparam logic [12:0] EMPTY = 13'h1FFF;
  localparam logic [12:0] FIRST = 13'd258;

  logic        clk;
  logic        rst;
  logic        init_start;
  logic        init_busy;
  logic        init_done;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [12:0] req_addr;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [12:0] rsp_data;
  logic [12:0] next_code;
  logic        table_full;
  logic        ram_en;
  logic        ram_wr;
  logic [12:0] ram_addr;
  logic [12:0] ram_wdata;
  logic [12:0] ram_rdata;

  code_table_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .init_start (init_start),
    .init_busy  (init_busy),
    .init_done  (init_done),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_hit    (rsp_hit),
    .rsp_data   (rsp_data),
    .next_code  (next_code),
    .table_full (table_full),
    .ram_en     (ram_en),
    .ram_wr     (ram_wr),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Four-bank RAM: registered read per bank, output picked by the live addr[1:0]
  logic [12:0] bank   [0:3][0:1023];
  logic [12:0] bank_q [0:3];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) bank[ram_addr[1:0]][ram_addr[11:2]] <= ram_wdata;
      else for (int b = 0; b < 4; b++) bank_q[b] <= bank[b][ram_addr[11:2]];
    end
  end
  assign ram_rdata = bank_q[ram_addr[1:0]];

  // Reference model
  typedef struct {
    int          due;
    bit          hit;
    logic [12:0] data;
  } rsp_t;

  rsp_t        exp_q [$];
  logic [12:0] mdl_mem [0:TBL-1];
  logic [12:0] mdl_next;
  bit          initialized;
  int          sweep_start;
  int          busy_until;
  int          rd_cycle;
  logic [12:0] rd_addr;
  int          done_cycle;
  int          cyc;
  bit          armed;
  bit          verbose;
  int          n_checks;
  int          n_fail;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    initialized = 1'b0;
    sweep_start = -1;
    busy_until  = 0;
    rd_cycle    = -1;
    done_cycle  = -1;
    mdl_next    = FIRST;
    exp_q.delete();
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle, advance the model
  task automatic cycle(input bit ist, input bit vld, input bit op, input logic [12:0] addr, input bit r);
    bit          sweeping, exp_ready, acc, full, start, exp_v;
    int          k;
    logic [27:0] exp_ram;
    rsp_t        e;

    rst = r; init_start = ist; req_valid = vld; req_op = op; req_addr = addr;

    if (sweep_start >= 0 && cyc == sweep_start + TBL + 1) begin
      initialized = 1'b1;
      mdl_next    = FIRST;
      done_cycle  = cyc;
      sweep_start = -1;
      for (int i = 0; i < TBL; i++) mdl_mem[i] = (i < 256) ? 13'(i) : EMPTY;
    end
    sweeping  = (sweep_start >= 0) && (cyc > sweep_start) && (cyc <= sweep_start + TBL);
    exp_ready = initialized && !sweeping && (cyc >= busy_until) && !ist;
    acc       = exp_ready && vld;
    full      = (mdl_next == 13'h1000);

    if (sweeping) begin
      k = cyc - sweep_start - 1;
      exp_ram = {1'b1, 1'b1, 13'(k), (k < 256) ? 13'(k) : EMPTY};
    end else if (acc && !op)
      exp_ram = {1'b1, 1'b0, addr, 13'd0};
    else if (acc && op && !full)
      exp_ram = {1'b1, 1'b1, addr, mdl_next};
    else if (cyc == rd_cycle)
      exp_ram = {1'b0, 1'b0, rd_addr, 13'd0};
    else
      exp_ram = '0;

    #4;
    if (armed) begin
      check_val("req_ready", req_ready, exp_ready);
      check_val("init_busy", init_busy, sweeping);
      check_val("init_done", init_done, cyc == done_cycle);
      check_val("next_code", next_code, mdl_next);
      check_val("table_full", table_full, full);
      check_val("ram_port", {ram_en, ram_wr, ram_addr, ram_wdata}, exp_ram);
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check_val("rsp_valid", rsp_valid, exp_v);
      if (exp_v) begin
        e = exp_q.pop_front();
        check_val("rsp_hit_data", {rsp_hit, rsp_data}, {e.hit, e.data});
        if (verbose) $display("rsp cyc=%0d hit=%0d data=%0h", cyc, rsp_hit, rsp_data);
      end
    end

    if (r) begin
      model_reset();
      armed = 1'b1;
    end else begin
      if (acc && !op) begin
        e.due = cyc + 2; e.data = mdl_mem[addr[11:0]]; e.hit = (e.data != EMPTY);
        exp_q.push_back(e);
        busy_until = cyc + 2;
        rd_cycle   = cyc + 1;
        rd_addr    = addr;
      end else if (acc && op && !full) begin
        e.due = cyc + 1; e.hit = 1'b1; e.data = mdl_next;
        exp_q.push_back(e);
        mdl_mem[addr[11:0]] = mdl_next;
        mdl_next = mdl_next + 13'd1;
      end else if (acc && op) begin
        e.due = cyc + 1; e.hit = 1'b0; e.data = EMPTY;
        exp_q.push_back(e);
      end
      start = ist && !sweeping && !(initialized && cyc < busy_until);
      if (start) sweep_start = cyc;
    end

    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_sweep();
    cycle(1'b1, 1'b0, 1'b0, 13'd0, 1'b0);
    repeat (TBL + 3) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 13'd5, 1'b0);
  endtask

  initial begin
    int guard;
    rst = 1'b1; init_start = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_addr = '0;
    cyc = 0; armed = 1'b0; verbose = 1'b1; n_checks = 0; n_fail = 0;
    model_reset();
    @(posedge clk); #1;

    // Reset, then IDLE ignores requests
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 13'd0, 1'b1);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 13'd5, 1'b0);

    // Full sweep
    run_sweep();

    // Directed lookups, insert followed by same-address lookup
    cycle(1'b0, 1'b1, 1'b0, 13'd65, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 13'd0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 13'd1000, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 13'd0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 13'd1000, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 13'd1000, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 13'd0, 1'b0);
    check_val("next_code_after_insert", next_code, 32'd259);

    // Random mix of lookups and inserts
    repeat (600) begin
      logic [12:0] a;
      a = ($urandom_range(0, 3) == 0) ? 13'(1000 + $urandom_range(0, 7)) : 13'($urandom_range(0, TBL - 1));
      cycle(1'b0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, 1'b0);
    end

    // Fill the allocator to saturation, then one insert while full
    verbose = 1'b0;
    guard = 0;
    while (mdl_next != 13'h1000 && guard < 5000) begin
      cycle(1'b0, 1'b1, 1'b1, 13'($urandom_range(0, TBL - 1)), 1'b0);
      guard++;
    end
    check_val("fill_budget", guard < 5000, 1'b1);
    verbose = 1'b1;
    cycle(1'b0, 1'b1, 1'b1, 13'd77, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 13'd0, 1'b0);
    check_val("table_full_sat", {table_full, next_code}, {1'b1, 13'h1000});

    // init_start ties with a request, then reset at sweep count 2000
    cycle(1'b1, 1'b1, 1'b0, 13'd5, 1'b0);
    repeat (2000) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 13'd5, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 13'd0, 1'b1);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 13'd5, 1'b0);

    // Restart sweep completes fully
    run_sweep();

    // Reset during RD_WAIT suppresses the response
    cycle(1'b0, 1'b1, 1'b0, 13'd65, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 13'd0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 13'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
